icache_assoc: RTL and testbench

- Parametrised N-way set-associative instruction cache with multi-word blocks and true-LRU replacement.
- Successor to the current single-configuration icache inside the caches wrapper.
- Sits between the pipeline fetch stage (imemREN/imemaddr/ihit/imemload) and the memory-controller instruction port (iREN/iaddr/iload/iwait).
- Hits are combinational; misses run a block-fill FSM.

---
 rtl/icache_assoc_pkg.sv | 17 +
 rtl/icache_assoc_lru.sv | 37 +++
 rtl/icache_assoc.sv | 205 ++++++++++++++++++++
 tb/tb_icache_assoc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_assoc_pkg.sv
// Shared types and constants for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int BYTE_OFF = 2;
  localparam int WORD_W   = 32;

  // Index width that stays at least 1 bit when a parameter is 1.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_assoc_lru.sv
// True-LRU age update and victim pick for one cache set (age 0 = most recent).
module icache_lru
  import icache_pkg::*;
#(
  parameter  int WAYS  = 2,
  localparam int AGE_W = safe_clog2(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]      way_i,
  input  logic                  access_i,
  output logic [WAYS*AGE_W-1:0] age_o,
  output logic [AGE_W-1:0]      lru_o
);

  logic [AGE_W-1:0] old_age;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    old_age = '0;
    lru_o   = '0;
    for (int j = 0; j < WAYS; j++) begin
      if (AGE_W'(j) == way_i) old_age = age_i[j*AGE_W +: AGE_W];
      if (age_i[j*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) lru_o = AGE_W'(j);
    end

    age_o = age_i;
    if (access_i) begin
      for (int j = 0; j < WAYS; j++) begin
        if (AGE_W'(j) == way_i)
          age_o[j*AGE_W +: AGE_W] = '0;
        else if (age_i[j*AGE_W +: AGE_W] < old_age)
          age_o[j*AGE_W +: AGE_W] = age_i[j*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with block fill and true-LRU replacement.
// Define ICACHE_STATS_EN to add hit_count / miss_count outputs.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int SETS      = 8,
  parameter int WAYS      = 2,
  parameter int BLK_WORDS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [31:0]       imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [31:0]       iload,
  input  logic              iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W  = $clog2(BLK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - BYTE_OFF - OFF_W - IDX_W;
  localparam int WCNT_W = safe_clog2(BLK_WORDS);
  localparam int AGE_W  = safe_clog2(WAYS);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [AGE_W-1:0]    victim_q, victim_d;
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [WAYS*AGE_W-1:0] age_q [SETS];
  logic [WAYS*AGE_W-1:0] age_d [SETS];

  logic [TAG_W-1:0]    tag_mem_q  [SETS][WAYS];
  logic [WORD_W-1:0]   data_mem_q [SETS][WAYS][BLK_WORDS];
  logic                tag_we, data_we;

  logic [ADDR_W-1:0]   word_addr;
  logic [WCNT_W-1:0]   req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit, hit_match, fill_last;
  logic [AGE_W-1:0]    hit_way, victim;
  logic [IDX_W-1:0]    lru_idx;
  logic [AGE_W-1:0]    lru_way, lru_victim;
  logic                lru_access;
  logic [WAYS*AGE_W-1:0] lru_age_next;

  // Lookup and LRU-port selection; kept apart from the state update to avoid a comb loop through icache_lru.
  always_comb begin
    word_addr = imemaddr >> BYTE_OFF;
    req_off   = WCNT_W'(word_addr & ADDR_W'(BLK_WORDS - 1));
    req_idx   = IDX_W'(word_addr >> OFF_W);
    req_tag   = TAG_W'(word_addr >> (OFF_W + IDX_W));

    hit_match = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_mem_q[req_idx][w] == req_tag)) begin
        hit_match = 1'b1;
        hit_way   = AGE_W'(w);
      end
    end

    hit       = imemREN && !flush && (state_q == IDLE) && hit_match;
    ihit      = hit;
    imemload  = hit ? data_mem_q[req_idx][hit_way][req_off] : '0;
    fill_last = (state_q == FILL) && !flush && !iwait &&
                (wcnt_q == WCNT_W'(BLK_WORDS - 1));

    lru_idx    = (state_q == FILL) ? fill_idx_q : req_idx;
    lru_way    = (state_q == FILL) ? victim_q   : hit_way;
    lru_access = hit || fill_last;
  end

  icache_lru #(.WAYS(WAYS)) u_lru (
    .age_i    (age_q[lru_idx]),
    .way_i    (lru_way),
    .access_i (lru_access),
    .age_o    (lru_age_next),
    .lru_o    (lru_victim)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    victim_d   = victim_q;
    valid_d    = valid_q;
    age_d      = age_q;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;

    // Prefer the lowest-numbered empty way before evicting the oldest.
    victim = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = AGE_W'(w);
    end

    if (lru_access) age_d[lru_idx] = lru_age_next;

    case (state_q)
      IDLE: begin
        if (flush) begin
          for (int s = 0; s < SETS; s++) valid_d[s] = '0;
        end else if (imemREN && !hit) begin
          fill_tag_d               = req_tag;
          fill_idx_d               = req_idx;
          victim_d                 = victim;
          wcnt_d                   = '0;
          valid_d[req_idx][victim] = 1'b0;
          state_d                  = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = (ADDR_W'({fill_tag_q, fill_idx_q}) << (BYTE_OFF + OFF_W)) |
                (ADDR_W'(wcnt_q) << BYTE_OFF);
        if (flush) begin
          for (int s = 0; s < SETS; s++) valid_d[s] = '0;
          state_d = IDLE;
        end else if (!iwait) begin
          data_we = 1'b1;
          if (fill_last) begin
            tag_we                        = 1'b1;
            valid_d[fill_idx_q][victim_q] = 1'b1;
            wcnt_d                        = '0;
            state_d                       = IDLE;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      victim_q   <= victim_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits gate every read of them.
  always_ff @(posedge CLK) begin
    if (tag_we)  tag_mem_q[fill_idx_q][victim_q] <= fill_tag_q;
    if (data_we) data_mem_q[fill_idx_q][victim_q][wcnt_q] <= iload;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + (hit ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q +
                   (((state_q == IDLE) && (state_d == FILL)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (SETS=8, WAYS=2, BLK_WORDS=2); stats checks when ICACHE_STATS_EN is defined.
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_assoc #(.SETS(8), .WAYS(2), .BLK_WORDS(2), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iload(iload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } hit_exp_t;

  hit_exp_t    hit_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wait_n = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign iload = mem_word(iaddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Memory: iwait high for wait_n cycles before each accepted word.
  always @(posedge CLK) begin
    #1;
    if (iREN && wait_n > 0 && wait_cnt < wait_n) begin
      iwait = 1'b1;
      wait_cnt++;
    end else begin
      iwait = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: compare presented hits and memory reads against the queued expectations.
  always @(negedge CLK) begin
    if (ihit === 1'b1) begin
      if (hit_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_hit: addr 0x%08h data 0x%08h", imemaddr, imemload);
      end else begin
        hit_exp_t e;
        e = hit_q.pop_front();
        check("hit_data", imemload, e.data);
        check("hit_cycle", cyc, e.cyc);
      end
    end
    if (iREN === 1'b1) begin
      if (addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_read: iaddr 0x%08h", iaddr);
      end else if (iwait) begin
        check("iaddr_held", iaddr, addr_q[0]);
      end else begin
        check("iaddr", iaddr, addr_q.pop_front());
      end
    end
  end

  // Issue a fetch; caller sits just after a rising edge. lat = cycles to the hit.
  task automatic fetch(input logic [31:0] a, input int lat, input bit miss);
    hit_exp_t e;
    bit got;
    imemREN  = 1'b1;
    imemaddr = a;
    e.data   = mem_word(a);
    e.cyc    = 32'(cyc + lat);
    hit_q.push_back(e);
    if (miss) begin
      addr_q.push_back(a & ~32'h7);
      addr_q.push_back((a & ~32'h7) + 32'h4);
    end
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge CLK);
      got = (ihit === 1'b1);
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL fetch_timeout: addr 0x%08h got no hit", a);
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_ihit", ihit, 0);
    check("rst_imemload", imemload, 0);
    check("rst_iREN", iREN, 0);
    check("rst_iaddr", iaddr, 0);
    @(posedge CLK); #1;

    // Cold miss then same-block hit.
    fetch(32'h40, 3, 1);
    fetch(32'h44, 0, 0);

    // LRU in set 0: 0x000 -> empty way1, 0x100 evicts 0x40, 0x200 evicts 0x100.
    fetch(32'h000, 3, 1);
    fetch(32'h100, 3, 1);
    fetch(32'h000, 0, 0);
    fetch(32'h200, 3, 1);
    fetch(32'h004, 0, 0);
    fetch(32'h100, 3, 1);

    // Three wait cycles per word: six extra cycles.
    wait_n = 3;
    fetch(32'h1008, 9, 1);
    wait_n = 0;
    fetch(32'h100C, 0, 0);

    // Flush one cycle into a fill of 0x80.
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    addr_q.push_back(32'h80);
    @(posedge CLK); #1;
    flush    = 1'b1;
    imemaddr = 32'h1008;
    @(negedge CLK);
    check("fill_no_hit", ihit, 0);
    @(posedge CLK); #1;
    flush   = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("flush_iREN", iREN, 0);
    @(posedge CLK); #1;
    fetch(32'h80, 3, 1);
    fetch(32'h1008, 3, 1);
    fetch(32'h000, 3, 1);

    // Reset in the middle of a fill.
    imemREN  = 1'b1;
    imemaddr = 32'h300;
    addr_q.push_back(32'h300);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST     = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("midrst_ihit", ihit, 0);
    check("midrst_iREN", iREN, 0);
    check("midrst_iaddr", iaddr, 0);
    @(posedge CLK); #1;
    fetch(32'h300, 3, 1);

    // One miss, five hit cycles, then an idle-state flush that must win over the miss.
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    fetch(32'h40, 3, 1);
    fetch(32'h40, 0, 0);
    fetch(32'h44, 0, 0);
    fetch(32'h40, 0, 0);
    fetch(32'h44, 0, 0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 5);
    check("miss_count", miss_count, 1);
`endif
    flush    = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    @(negedge CLK);
    check("flush_idle_ihit", ihit, 0);
    @(posedge CLK); #1;
    flush   = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("flush_wins_iREN", iREN, 0);
`ifdef ICACHE_STATS_EN
    check("hit_count_flush", hit_count, 5);
    check("miss_count_flush", miss_count, 1);
`endif
    @(posedge CLK); #1;
    fetch(32'h40, 3, 1);

    repeat (2) @(posedge CLK);
    check("hit_q_drained", hit_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
